mem_bridge: RTL and testbench
=============================

// Module: mem_bridge
// PURPOSE
//  Sits directly downstream of the suro-v multi-cycle datapath. Turns its byte-addressed,
//  funct3-sized load/store request into word-aligned bus transactions with byte strobes.
//  Splits misaligned accesses into two beats. Aligns and sign/zero-extends load data and
//  returns a one-cycle completion pulse, so the controller can stall on wait-stated memory.
// PARAMETERS
//  ALLOW_MISALIGNED  1   1: split crossing accesses into 2 beats; 0: flag core_err, no bus traffic
//  BUS_AW            32  bus address width; bus_addr[1:0] always 0
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  core_req       in   1   start access; sampled only in IDLE
//  core_we        in   1   1 = store, 0 = load
//  core_addr      in   32  byte address
//  core_size      in   3   mem_addr_t (funct3): B=000 H=001 W=010 BU=100 HU=101
//  core_wdata     in   32  store data, LSB-justified
//  core_rdata     out  32  extended load data; held until next accept
//  core_done      out  1   1-cycle pulse, access complete
//  core_err       out  1   valid with core_done: bus error or disallowed misalign
//  busy           out  1   high from accept until the cycle after core_done
//  bus_req_valid  out  1   request valid; held with payload stable until bus_req_ready
//  bus_req_ready  in   1   slave accepts request
//  bus_addr       out  BUS_AW  word-aligned address
//  bus_we         out  1   write
//  bus_wstrb      out  4   byte strobes; 0000 on reads
//  bus_wdata      out  32  lane-shifted write data
//  bus_rsp_valid  in   1   response (read data / write ack), one per accepted request
//  bus_rdata      in   32  read word
//  bus_rsp_err    in   1   error, valid with bus_rsp_valid
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0, including core_rdata; captured request regs cleared.
//  - Accept: IDLE & core_req. Latch we/addr/size/wdata. off=addr[1:0], bytes=1/2/4.
//    cross = off+bytes>4.
//  - States: IDLE -> REQ0 -> WAIT0 -> (cross ? REQ1 -> WAIT1) -> RESP -> IDLE.
//  - REQx: bus_req_valid=1; advance on bus_req_ready. WAITx: advance on bus_rsp_valid.
//    Req accepted and response in the same cycle is not legal on the bus (min 1 cycle gap).
//  - Beat0 addr = {addr[31:2],2'b00}. Beat1 addr = beat0+4, mod 2^32 (0xFFFFFFFC -> 0).
//  - Strobes: mask = ((1<<bytes)-1) << off, 8 bits. Beat0 wstrb=mask[3:0], beat1=mask[7:4].
//    Wdata 64-bit = wdata << 8*off. Beat0 = [31:0], beat1 = [63:32].
//  - Loads: merged = {beat1_rdata, beat0_rdata} >> 8*off; keep low bytes.
//    Sign-extend B/H, zero-extend BU/HU, W passes through. Reserved size codes act as W.
//  - Error: bus_rsp_err on beat0 skips beat1 and goes to RESP with core_err=1.
//    core_rdata is still updated from whatever was merged.
//  - Misaligned with ALLOW_MISALIGNED=0: IDLE -> RESP directly; core_err=1, no bus request,
//    core_rdata unchanged.
//  - RESP: core_done=1 for one cycle, core_rdata/core_err registered; core_req ignored.
//    Earliest new accept is the following cycle.
//  - Latency with zero-wait bus: aligned = 4 cycles accept->done; split = 6.
//  - bus_rsp_valid while in IDLE/REQx (e.g. stale after reset) is dropped silently.
//  - rst mid-transaction: abort immediately; bus_req_valid drops the next edge
//    (protocol violation accepted on reset); no core_done.
//  - core_req while busy: ignored, not queued.
// STRUCTURE
//  - Shared package (suro_pkg): mem_addr_t and MEM_B/H/W/BU/HU, word_t, and the
//    mem_bridge_state_t enum.
//  - Sub-module lane_align: combinational; inputs off, size, 64-bit merged read, wdata;
//    outputs strobes, shifted wdata, extended rdata. mem_bridge holds the FSM and regs.
// TESTING
//  - LW 0x100, bus returns 0xDEADBEEF, zero wait -> bus_addr=0x100, wstrb=0,
//    core_rdata=0xDEADBEEF, done 4 cycles after accept.
//  - LB 0x103 with rdata 0x80FFFFFF -> 0xFFFFFF80; LBU same -> 0x00000080;
//    LHU 0x102 -> 0x000080FF.
//  - SW 0x201, wdata 0x11223344 -> beat0 addr 0x200 wstrb 1110 wdata 0x22334400;
//    beat1 addr 0x204 wstrb 0001 wdata 0x00000011.
//  - LH 0xFFFFFFFF: beats return 0xAA000000 then 0x000000BB -> addrs 0xFFFFFFFC, 0x0;
//    core_rdata=0xFFFFBBAA.
//  - bus_req_ready low 5 cycles and rsp_err=1 on beat0 of split LW 0x2 -> payload stable
//    while stalled, no beat1, core_done+core_err=1.
//  - rst asserted in WAIT0, then stale rsp_valid arrives in IDLE -> no core_done, state IDLE;
//    next LW completes normally.

Source files
------------

// File: rtl/suro_pkg.sv
// Shared suro-v types: memory access size codes, data word, and mem_bridge FSM states.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package suro_pkg;

  // funct3 access size encoding used by loads and stores
  typedef logic [2:0] mem_addr_t;

  localparam mem_addr_t MEM_B  = 3'b000;
  localparam mem_addr_t MEM_H  = 3'b001;
  localparam mem_addr_t MEM_W  = 3'b010;
  localparam mem_addr_t MEM_BU = 3'b100;
  localparam mem_addr_t MEM_HU = 3'b101;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MB_IDLE  = 3'd0,
    MB_REQ0  = 3'd1,
    MB_WAIT0 = 3'd2,
    MB_REQ1  = 3'd3,
    MB_WAIT1 = 3'd4,
    MB_RESP  = 3'd5
  } mem_bridge_state_t;

  // Access width in bytes from the low two funct3 bits; reserved codes fall to a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_lane_align.sv
// Byte-lane steering for mem_bridge: store strobes/data shift, load merge and extension.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
// Ports: off (byte offset), size (funct3), merged_rdata ({beat1,beat0}), wdata ->
//        strb (8 lanes over two beats), wdata_sh (64-bit shifted store data), rdata_ext.
module lane_align
  import suro_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [63:0] merged_rdata,
  input  logic [31:0] wdata,
  output logic [7:0]  strb,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [7:0]  base_mask;
  logic [5:0]  sh;
  logic [31:0] rd_lo;

  always_comb begin
    case (size[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    sh       = {off, 3'b000};
    strb     = base_mask << off;
    wdata_sh = {32'h0, wdata} << sh;
    // Picking 32 bits at the byte offset is the same as shifting right and keeping the low word.
    rd_lo    = merged_rdata[sh +: 32];
    case (size)
      MEM_B:   rdata_ext = {{24{rd_lo[7]}},  rd_lo[7:0]};
      MEM_H:   rdata_ext = {{16{rd_lo[15]}}, rd_lo[15:0]};
      MEM_BU:  rdata_ext = {24'h0, rd_lo[7:0]};
      MEM_HU:  rdata_ext = {16'h0, rd_lo[15:0]};
      default: rdata_ext = rd_lo;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Core load/store to word bus bridge: aligns, splits line-crossing accesses, extends loads.
// Latency: zero-wait bus gives accept->core_done of 4 cycles (aligned) or 6 (split).
// Backpressure: holds bus_req_valid/payload until bus_req_ready; waits on bus_rsp_valid.
// Ports: core_* request/completion side, busy status, bus_* word-aligned request/response side.
module mem_bridge
  import suro_pkg::*;
#(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int BUS_AW           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [2:0]        core_size,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_done,
  output logic              core_err,
  output logic              busy,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [BUS_AW-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rsp_err
);

  mem_bridge_state_t state, state_nxt;

  logic      r_we;
  word_t     r_addr;
  mem_addr_t r_size;
  word_t     r_wdata;
  word_t     beat0_rdata;
  word_t     beat1_rdata;
  logic      r_err;
  logic      r_nobus;   // misalign rejected without touching the bus

  logic        accept;
  logic        cross_in;
  logic        cross_r;
  logic        reject_in;
  logic        beat_sel;
  word_t       beat_addr;
  logic [7:0]  strb;
  logic [63:0] wdata_sh;
  word_t       rdata_ext;

  assign accept    = (state == MB_IDLE) && core_req;
  assign cross_in  = ({1'b0, core_addr[1:0]} + size_bytes(core_size[1:0])) > 3'd4;
  assign cross_r   = ({1'b0, r_addr[1:0]} + size_bytes(r_size[1:0])) > 3'd4;
  assign reject_in = cross_in && (ALLOW_MISALIGNED == 0);

  always_comb begin
    state_nxt = state;
    case (state)
      MB_IDLE:  if (core_req) state_nxt = reject_in ? MB_RESP : MB_REQ0;
      MB_REQ0:  if (bus_req_ready) state_nxt = MB_WAIT0;
      // An error on the first beat abandons the second one.
      MB_WAIT0: if (bus_rsp_valid) state_nxt = (cross_r && !bus_rsp_err) ? MB_REQ1 : MB_RESP;
      MB_REQ1:  if (bus_req_ready) state_nxt = MB_WAIT1;
      MB_WAIT1: if (bus_rsp_valid) state_nxt = MB_RESP;
      MB_RESP:  state_nxt = MB_IDLE;
      default:  state_nxt = MB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MB_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      beat0_rdata <= '0;
      beat1_rdata <= '0;
      r_err       <= 1'b0;
      r_nobus     <= 1'b0;
      core_rdata  <= '0;
      core_done   <= 1'b0;
      core_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Busy stays up through the completion cycle, which follows RESP.
      busy      <= (state_nxt != MB_IDLE) || (state == MB_RESP);
      core_done <= (state == MB_RESP);
      core_err  <= (state == MB_RESP) && r_err;

      if (accept) begin
        r_we        <= core_we;
        r_addr      <= core_addr;
        r_size      <= core_size;
        r_wdata     <= core_wdata;
        r_err       <= reject_in;
        r_nobus     <= reject_in;
        beat0_rdata <= '0;
        beat1_rdata <= '0;
      end

      if (state == MB_WAIT0 && bus_rsp_valid) begin
        beat0_rdata <= bus_rdata;
        r_err       <= r_err | bus_rsp_err;
      end
      if (state == MB_WAIT1 && bus_rsp_valid) begin
        beat1_rdata <= bus_rdata;
        r_err       <= r_err | bus_rsp_err;
      end

      if (state == MB_RESP && !r_we && !r_nobus) begin
        core_rdata <= rdata_ext;
      end
    end
  end

  lane_align u_lane_align (
    .off          (r_addr[1:0]),
    .size         (r_size),
    .merged_rdata ({beat1_rdata, beat0_rdata}),
    .wdata        (r_wdata),
    .strb         (strb),
    .wdata_sh     (wdata_sh),
    .rdata_ext    (rdata_ext)
  );

  // Payload is a pure function of state and captured regs, so it is stable while stalled.
  assign bus_req_valid = (state == MB_REQ0) || (state == MB_REQ1);
  assign beat_sel      = (state == MB_REQ1);
  assign beat_addr     = {r_addr[31:2], 2'b00} + (beat_sel ? 32'd4 : 32'd0);
  assign bus_addr      = bus_req_valid ? BUS_AW'(beat_addr) : '0;
  assign bus_we        = bus_req_valid && r_we;
  assign bus_wstrb     = (bus_req_valid && r_we) ? (beat_sel ? strb[7:4] : strb[3:0]) : 4'b0000;
  assign bus_wdata     = (bus_req_valid && r_we) ? (beat_sel ? wdata_sh[63:32] : wdata_sh[31:0]) : 32'h0;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: small inline bus responder, hand-computed expectations.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [2:0]  core_size;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_done;
  logic        core_err;
  logic        busy;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        bus_rsp_err;

  int checks   = 0;
  int failures = 0;

  // Results of the last access driven by run_access
  int          r_lat;
  int          r_beats;
  logic        r_done;
  logic        r_err;
  logic        r_stable;
  logic [31:0] r_a0, r_a1, r_w0, r_w1;
  logic [3:0]  r_s0, r_s1;

  mem_bridge #(.ALLOW_MISALIGNED(1), .BUS_AW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_size     (core_size),
    .core_wdata    (core_wdata),
    .core_rdata    (core_rdata),
    .core_done     (core_done),
    .core_err      (core_err),
    .busy          (busy),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .bus_rsp_err   (bus_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access and act as the bus slave: stall the first request for 'stall' cycles,
  // answer each accepted request one cycle later. Returns at the core_done cycle (or timeout).
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic [31:0] rd0,
                            input logic [31:0] rd1, input logic err0, input int stall);
    int   st;
    logic pend;
    logic [31:0] snap_a, snap_w;
    logic [3:0]  snap_s;
    st = stall; pend = 1'b0;
    r_lat = 0; r_beats = 0; r_done = 1'b0; r_err = 1'b0; r_stable = 1'b1;
    r_a0 = '0; r_a1 = '0; r_w0 = '0; r_w1 = '0; r_s0 = '0; r_s1 = '0;
    snap_a = '0; snap_w = '0; snap_s = '0;
    core_we = we; core_addr = addr; core_size = size; core_wdata = wdata; core_req = 1'b1;
    tick;
    core_req = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rdata = '0;
      if (core_done) begin
        r_done = 1'b1; r_lat = c; r_err = core_err;
        break;
      end
      if (pend) begin
        bus_rsp_valid = 1'b1;
        bus_rdata     = (r_beats == 1) ? rd0 : rd1;
        bus_rsp_err   = (r_beats == 1) ? err0 : 1'b0;
        pend          = 1'b0;
      end else if (bus_req_valid) begin
        if (r_beats == 0 && stall > 0) begin
          if (st == stall) begin
            snap_a = bus_addr; snap_w = bus_wdata; snap_s = bus_wstrb;
          end else if (bus_addr !== snap_a || bus_wdata !== snap_w || bus_wstrb !== snap_s) begin
            r_stable = 1'b0;
          end
        end
        if (st > 0) begin
          st--;
        end else begin
          if (r_beats == 0) begin
            r_a0 = bus_addr; r_s0 = bus_wstrb; r_w0 = bus_wdata;
          end else begin
            r_a1 = bus_addr; r_s1 = bus_wstrb; r_w1 = bus_wdata;
          end
          bus_req_ready = 1'b1;
          r_beats++;
          pend = 1'b1;
        end
      end
      tick;
    end
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rdata = '0;
  endtask

  logic done_any;

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_size = '0;
    core_wdata = '0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    bus_rsp_err = 1'b0;
    repeat (3) tick;

    // Reset state
    check("rst_done",   32'(core_done), 32'h0);
    check("rst_err",    32'(core_err), 32'h0);
    check("rst_rdata",  core_rdata, 32'h0);
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_reqv",   32'(bus_req_valid), 32'h0);
    check("rst_addr",   bus_addr, 32'h0);
    check("rst_wstrb",  32'(bus_wstrb), 32'h0);
    rst = 1'b0;
    tick;

    // LW 0x100, aligned, zero wait
    run_access(1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    check("lw_done",  32'(r_done), 32'h1);
    check("lw_lat",   32'(r_lat), 32'd4);
    check("lw_beats", 32'(r_beats), 32'd1);
    check("lw_addr",  r_a0, 32'h100);
    check("lw_wstrb", 32'(r_s0), 32'h0);
    check("lw_rdata", core_rdata, 32'hDEADBEEF);
    check("lw_busy_at_done", 32'(busy), 32'h1);
    tick;
    check("lw_busy_after", 32'(busy), 32'h0);
    check("lw_done_pulse", 32'(core_done), 32'h0);

    // Byte/half extension
    run_access(1'b0, 32'h103, 3'b000, 32'h0, 32'h80FFFFFF, 32'h0, 1'b0, 0);
    check("lb_addr",  r_a0, 32'h100);
    check("lb_rdata", core_rdata, 32'hFFFFFF80);
    run_access(1'b0, 32'h103, 3'b100, 32'h0, 32'h80FFFFFF, 32'h0, 1'b0, 0);
    check("lbu_rdata", core_rdata, 32'h00000080);
    run_access(1'b0, 32'h102, 3'b101, 32'h0, 32'h80FFFFFF, 32'h0, 1'b0, 0);
    check("lhu_beats", 32'(r_beats), 32'd1);
    check("lhu_rdata", core_rdata, 32'h000080FF);

    // Split store SW 0x201
    run_access(1'b1, 32'h201, 3'b010, 32'h11223344, 32'h0, 32'h0, 1'b0, 0);
    check("sw_beats",  32'(r_beats), 32'd2);
    check("sw_lat",    32'(r_lat), 32'd6);
    check("sw_a0",     r_a0, 32'h200);
    check("sw_s0",     32'(r_s0), 32'hE);
    check("sw_w0",     r_w0, 32'h22334400);
    check("sw_a1",     r_a1, 32'h204);
    check("sw_s1",     32'(r_s1), 32'h1);
    check("sw_w1",     r_w1, 32'h00000011);
    check("sw_err",    32'(r_err), 32'h0);

    // Split load wrapping the address space
    run_access(1'b0, 32'hFFFFFFFF, 3'b001, 32'h0, 32'hAA000000, 32'h000000BB, 1'b0, 0);
    check("lh_wrap_a0",    r_a0, 32'hFFFFFFFC);
    check("lh_wrap_a1",    r_a1, 32'h0);
    check("lh_wrap_s0",    32'(r_s0), 32'h0);
    check("lh_wrap_lat",   32'(r_lat), 32'd6);
    check("lh_wrap_rdata", core_rdata, 32'hFFFFBBAA);

    // Split LW 0x2, five stall cycles, error on beat0
    run_access(1'b0, 32'h2, 3'b010, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 5);
    check("err_stable", 32'(r_stable), 32'h1);
    check("err_a0",     r_a0, 32'h0);
    check("err_beats",  32'(r_beats), 32'd1);
    check("err_done",   32'(r_done), 32'h1);
    check("err_flag",   32'(r_err), 32'h1);
    check("err_lat",    32'(r_lat), 32'd9);
    tick;
    check("err_no_beat1", 32'(bus_req_valid), 32'h0);

    // Reset while waiting for beat0 response, then a stale response
    core_we = 1'b0; core_addr = 32'h300; core_size = 3'b010; core_req = 1'b1;
    tick;
    core_req = 1'b0;
    check("mid_reqv", 32'(bus_req_valid), 32'h1);
    bus_req_ready = 1'b1;
    tick;
    bus_req_ready = 1'b0;
    check("mid_busy_wait0", 32'(busy), 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_reqv", 32'(bus_req_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    done_any = core_done;
    bus_rsp_valid = 1'b1; bus_rdata = 32'h55555555;
    tick;
    bus_rsp_valid = 1'b0; bus_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      done_any = done_any | core_done | busy | bus_req_valid;
      tick;
    end
    check("stale_rsp_quiet", 32'(done_any), 32'h0);

    run_access(1'b0, 32'h40, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    check("post_rst_lat",   32'(r_lat), 32'd4);
    check("post_rst_addr",  r_a0, 32'h40);
    check("post_rst_rdata", core_rdata, 32'hCAFEF00D);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
